// File: rtl/ad9228_multi_ch_capture.sv
// AD9228 capture engine: FCO frame lock, two-slice gearbox and triggered capture into an FWFT FIFO.
// Define AD9228_SELF_TRIG_EN to add the trig_level port and sample-threshold self-triggering.
module ad9228_multi_ch_capture #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned IN_W       = 6,
  parameter int unsigned FIFO_DEPTH = 2048,
  parameter int unsigned LEN_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         ser_valid,
  input  logic [NUM_CH*IN_W-1:0]       ser_data,
  input  logic [IN_W-1:0]              fco_bits,
  input  logic                         arm,
  input  logic                         trig,
  input  logic [LEN_W-1:0]             capture_len,
  output logic                         locked,
  output logic                         bitslip,
  output logic                         frame_err,
  output logic [1:0]                   state,
  input  logic                         fifo_rd_en,
`ifdef AD9228_SELF_TRIG_EN
  input  logic [DATA_WIDTH-1:0]        trig_level,
`endif
  output logic [NUM_CH*DATA_WIDTH-1:0] fifo_dout,
  output logic                         fifo_not_empty,
  output logic                         fifo_full,
  output logic                         overflow
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned FW = NUM_CH * DATA_WIDTH;

  typedef enum logic {StHunt, StLock} align_e;
  typedef enum logic [1:0] {StIdle = 2'd0, StArmed = 2'd1, StCapture = 2'd2, StDone = 2'd3} cap_e;

  align_e     align_q, align_d;
  logic [1:0] alt_cnt_q, alt_cnt_d;
  logic [3:0] slip_hold_q, slip_hold_d;
  logic       bitslip_q, bitslip_d;
  logic       last_hi_q, last_hi_d;
  logic       err_set;
  logic       fco_hi, fco_lo;

  assign fco_hi = &fco_bits;
  assign fco_lo = ~|fco_bits;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      align_q     <= StHunt;
      alt_cnt_q   <= 2'd0;
      slip_hold_q <= 4'd0;
      bitslip_q   <= 1'b0;
      last_hi_q   <= 1'b0;
    end else begin
      align_q     <= align_d;
      alt_cnt_q   <= alt_cnt_d;
      slip_hold_q <= slip_hold_d;
      bitslip_q   <= bitslip_d;
      last_hi_q   <= last_hi_d;
    end
  end

  always_comb begin
    align_d     = align_q;
    alt_cnt_d   = alt_cnt_q;
    slip_hold_d = slip_hold_q;
    bitslip_d   = 1'b0;
    last_hi_d   = last_hi_q;
    err_set     = 1'b0;
    if (ser_valid) begin
      if (slip_hold_q != 4'd0) slip_hold_d = slip_hold_q - 4'd1;
      unique case (align_q)
        StHunt: begin
          if (!fco_hi && !fco_lo) begin
            alt_cnt_d = 2'd0;
            if (slip_hold_q == 4'd0) begin
              bitslip_d   = 1'b1;
              slip_hold_d = 4'd8;
            end
          end else if (fco_hi == !alt_cnt_q[0]) begin
            // Even count expects HI, odd count expects LO.
            if (alt_cnt_q == 2'd3) begin
              align_d   = StLock;
              alt_cnt_d = 2'd0;
              last_hi_d = 1'b0;
            end else begin
              alt_cnt_d = alt_cnt_q + 2'd1;
            end
          end else begin
            alt_cnt_d = fco_hi ? 2'd1 : 2'd0;
          end
        end
        StLock: begin
          if ((!fco_hi && !fco_lo) || (fco_hi == last_hi_q)) begin
            err_set   = 1'b1;
            align_d   = StHunt;
            alt_cnt_d = 2'd0;
          end else begin
            last_hi_d = fco_hi;
          end
        end
        default: align_d = StHunt;
      endcase
    end
  end

  always_comb begin
    locked  = (align_q == StLock);
    bitslip = bitslip_q;
  end

  // Gearbox: HI slice holds the upper halves, the following LO slice completes the samples.
  logic [NUM_CH*IN_W-1:0] upper_q;
  logic [FW-1:0]          frame_q, sample_asm;
  logic                   frame_valid_q;
  logic                   take_hi, take_lo;

  assign take_hi = ser_valid && (align_q == StLock) && fco_hi && !last_hi_q;
  assign take_lo = ser_valid && (align_q == StLock) && fco_lo && last_hi_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_asm
    assign sample_asm[c*DATA_WIDTH +: DATA_WIDTH] = {upper_q[c*IN_W +: IN_W],
                                                     ser_data[c*IN_W +: IN_W]};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      upper_q       <= '0;
      frame_q       <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      frame_valid_q <= take_lo;
      if (take_hi) upper_q <= ser_data;
      if (take_lo) frame_q <= sample_asm;
    end
  end

  logic self_hit;
`ifdef AD9228_SELF_TRIG_EN
  logic [NUM_CH-1:0] ch_hit;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_hit
    assign ch_hit[c] = frame_q[c*DATA_WIDTH +: DATA_WIDTH] >= trig_level;
  end
  assign self_hit = frame_valid_q && (|ch_hit);
`else
  assign self_hit = 1'b0;
`endif

  // Capture FSM
  cap_e             cap_q, cap_d;
  logic [LEN_W-1:0] len_q, cnt_q;
  logic             arm_take, wr_req, last_frame;
  logic             frame_err_q, overflow_q;

  assign last_frame = (cnt_q + LEN_W'(1)) == len_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cap_q <= StIdle;
    else       cap_q <= cap_d;
  end

  always_comb begin
    cap_d = cap_q;
    unique case (cap_q)
      StIdle, StDone: if (arm) cap_d = StArmed;
      StArmed: begin
        if (trig || self_hit) begin
          if (len_q == '0)             cap_d = StDone;
          else if (wr_req && last_frame) cap_d = StDone;
          else                         cap_d = StCapture;
        end
      end
      StCapture: if (wr_req && last_frame) cap_d = StDone;
      default: cap_d = StIdle;
    endcase
  end

  always_comb begin
    arm_take = arm && ((cap_q == StIdle) || (cap_q == StDone));
    // A self-trigger frame is itself the first frame captured.
    wr_req   = frame_valid_q &&
               ((cap_q == StCapture) || ((cap_q == StArmed) && self_hit && (len_q != '0)));
    state    = cap_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      len_q       <= '0;
      cnt_q       <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (arm_take) begin
        len_q <= capture_len;
        cnt_q <= '0;
      end else if (wr_req) begin
        cnt_q <= cnt_q + LEN_W'(1);
      end
      if (err_set)       frame_err_q <= 1'b1;
      else if (arm_take) frame_err_q <= 1'b0;
      if (wr_req && fifo_full) overflow_q <= 1'b1;
      else if (arm_take)       overflow_q <= 1'b0;
    end
  end

  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;

  // FWFT FIFO
  logic [FW-1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LEN_W-1:0] count_q;
  logic             do_wr, do_rd;

  assign fifo_full      = (count_q == LEN_W'(FIFO_DEPTH));
  assign fifo_not_empty = (count_q != '0);
  assign do_wr          = wr_req && !fifo_full;
  assign do_rd          = fifo_rd_en && fifo_not_empty;
  assign fifo_dout      = fifo_not_empty ? mem[rd_ptr_q] : '0;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_q] <= frame_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + LEN_W'(1);
        2'b01:   count_q <= count_q - LEN_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_ad9228_multi_ch_capture.sv
// Bench for ad9228_multi_ch_capture: directed FCO/data slices; expected frames are queued at
// stimulus time and compared by a monitor on every FIFO pop.
module tb_ad9228_multi_ch_capture;
  localparam int NUM_CH = 4;
  localparam int DW     = 12;
  localparam int IN_W   = 6;
  localparam int DEPTH  = 16;
  localparam int LEN_W  = 5;

  logic                   clk = 1'b0;
  logic                   rstn = 1'b0;
  logic                   ser_valid = 1'b0;
  logic [NUM_CH*IN_W-1:0] ser_data = '0;
  logic [IN_W-1:0]        fco_bits = '0;
  logic                   arm = 1'b0;
  logic                   trig = 1'b0;
  logic [LEN_W-1:0]       capture_len = '0;
  logic                   locked, bitslip, frame_err;
  logic [1:0]             state;
  logic                   fifo_rd_en = 1'b0;
  logic [NUM_CH*DW-1:0]   fifo_dout;
  logic                   fifo_not_empty, fifo_full, overflow;
`ifdef AD9228_SELF_TRIG_EN
  logic [DW-1:0]          trig_level = 12'h800;
`endif

  int total = 0;
  int bad = 0;
  int slip_cnt = 0;
  int cyc = 0;
  int last_slip = -100;
  logic slip_prev = 1'b0;
  logic [NUM_CH*DW-1:0] exp_q[$];
  logic [NUM_CH*DW-1:0] exp_head;

  always #5 clk = ~clk;

  ad9228_multi_ch_capture #(
    .NUM_CH(NUM_CH), .DATA_WIDTH(DW), .IN_W(IN_W), .FIFO_DEPTH(DEPTH), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rstn(rstn), .ser_valid(ser_valid), .ser_data(ser_data), .fco_bits(fco_bits),
    .arm(arm), .trig(trig), .capture_len(capture_len), .locked(locked), .bitslip(bitslip),
    .frame_err(frame_err), .state(state), .fifo_rd_en(fifo_rd_en),
`ifdef AD9228_SELF_TRIG_EN
    .trig_level(trig_level),
`endif
    .fifo_dout(fifo_dout), .fifo_not_empty(fifo_not_empty), .fifo_full(fifo_full),
    .overflow(overflow)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted pop is compared against the queued frame.
  always @(negedge clk) begin
    if (fifo_rd_en && fifo_not_empty) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL fifo_pop: got %h want <no entry expected>", fifo_dout);
      end else begin
        exp_head = exp_q.pop_front();
        if (fifo_dout !== exp_head) begin
          bad++;
          $display("FAIL fifo_pop: got %h want %h", fifo_dout, exp_head);
        end
      end
    end
  end

  // Bitslip must be single-cycle and at least 9 slices apart.
  always @(negedge clk) begin
    cyc++;
    if (bitslip) begin
      slip_cnt++;
      total++;
      if (slip_prev || (cyc - last_slip) < 9) begin
        bad++;
        $display("FAIL bitslip_spacing: got %0d cycles want >= 9", cyc - last_slip);
      end
      last_slip = cyc;
    end
    slip_prev = bitslip;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic slice(input logic [IN_W-1:0] f, input logic [NUM_CH*IN_W-1:0] d);
    ser_valid = 1'b1;
    fco_bits  = f;
    ser_data  = d;
    tick();
    ser_valid = 1'b0;
  endtask

  function automatic logic [NUM_CH*DW-1:0] mk_frame(input int i);
    logic [NUM_CH*DW-1:0] fr;
    for (int c = 0; c < NUM_CH; c++) fr[c*DW +: DW] = DW'(i * 41 + c * 300 + 7);
    return fr;
  endfunction

  task automatic send_frame(input logic [NUM_CH*DW-1:0] fr, input bit expect_wr);
    logic [NUM_CH*IN_W-1:0] hi, lo;
    for (int c = 0; c < NUM_CH; c++) begin
      hi[c*IN_W +: IN_W] = fr[c*DW+IN_W +: IN_W];
      lo[c*IN_W +: IN_W] = fr[c*DW +: IN_W];
    end
    if (expect_wr) exp_q.push_back(fr);
    slice(6'h3F, hi);
    slice(6'h00, lo);
  endtask

  task automatic arm_pulse(input logic [LEN_W-1:0] len);
    capture_len = len;
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic trig_pulse();
    trig = 1'b1;
    tick();
    trig = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (fifo_not_empty && g < 64) begin
      fifo_rd_en = 1'b1;
      tick();
      g++;
    end
    fifo_rd_en = 1'b0;
    check("drain_bound", 64'(g < 64), 1);
    check("scoreboard_empty", exp_q.size(), 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_bitslip"}, bitslip, 0);
    check({tag, "_frame_err"}, frame_err, 0);
    check({tag, "_state"}, state, 0);
    check({tag, "_not_empty"}, fifo_not_empty, 0);
    check({tag, "_full"}, fifo_full, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_dout"}, fifo_dout, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) tick();
    check_reset_values("reset");
    rstn = 1'b1;
    tick();

    // Clean lock: HI, LO, HI, LO
    slice(6'h3F, 24'h123456);
    slice(6'h00, 24'h234567);
    slice(6'h3F, 24'h345678);
    check("lock_after_3", locked, 0);
    slice(6'h00, 24'h456789);
    check("lock_after_4", locked, 1);
    check("lock_no_slip", slip_cnt, 0);
    check("lock_no_err", frame_err, 0);

    // Capture of 5 frames; a frame in ARMED must not be written
    arm_pulse(5);
    check("cap_armed", state, 1);
    send_frame(mk_frame(100), 1'b0);
    trig_pulse();
    check("cap_capture", state, 2);
    check("cap_empty_at_trig", fifo_not_empty, 0);
    send_frame(mk_frame(0), 1'b1);
    send_frame(mk_frame(1), 1'b1);
    arm_pulse(2);
    check("arm_ignored_in_capture", state, 2);
    for (int i = 2; i < 7; i++) send_frame(mk_frame(i), i < 5);
    tick();
    check("cap_done", state, 3);
    check("cap_not_empty", fifo_not_empty, 1);
    check("cap_not_full", fifo_full, 0);
    drain();

    // Zero-length capture
    arm_pulse(0);
    check("len0_armed", state, 1);
    trig_pulse();
    check("len0_done", state, 3);
    send_frame(mk_frame(9), 1'b0);
    tick();
    check("len0_no_write", fifo_not_empty, 0);

    // Misaligned FCO: first bad slice drops lock, then slips every 9 slices
    slip_cnt = 0;
    for (int i = 0; i < 20; i++) slice(6'b011111, '0);
    tick();
    check("mis_slip_count", slip_cnt, 3);
    check("mis_unlocked", locked, 0);
    check("mis_frame_err", frame_err, 1);
    slice(6'h3F, '0);
    slice(6'h00, '0);
    slice(6'h3F, '0);
    slice(6'h00, '0);
    check("relock", locked, 1);
    check("relock_err_sticky", frame_err, 1);

    // Overflow: 20 frames into a 16-deep FIFO
    arm_pulse(20);
    check("ovf_err_cleared", frame_err, 0);
    check("ovf_armed", state, 1);
    trig_pulse();
    for (int i = 0; i < 20; i++) send_frame(mk_frame(20 + i), i < 16);
    tick();
    tick();
    check("ovf_full", fifo_full, 1);
    check("ovf_flag", overflow, 1);
    check("ovf_done", state, 3);
    drain();
    check("ovf_full_after_drain", fifo_full, 0);
    check("ovf_flag_sticky", overflow, 1);

`ifdef AD9228_SELF_TRIG_EN
    // Self-trigger on channel 2 crossing 12'h800
    arm_pulse(3);
    send_frame({12'h100, 12'h7FF, 12'h100, 12'h100}, 1'b0);
    send_frame({12'h100, 12'h800, 12'h100, 12'h100}, 1'b1);
    send_frame({12'h101, 12'h010, 12'h102, 12'h103}, 1'b1);
    send_frame({12'h201, 12'h020, 12'h202, 12'h203}, 1'b1);
    send_frame({12'h301, 12'h030, 12'h302, 12'h303}, 1'b0);
    tick();
    check("self_done", state, 3);
    drain();
`endif

    // Reset in the middle of a capture
    arm_pulse(5);
    check("rst_ovf_cleared", overflow, 0);
    trig_pulse();
    send_frame(mk_frame(50), 1'b0);
    send_frame(mk_frame(51), 1'b0);
    tick();
    check("rst_pre_not_empty", fifo_not_empty, 1);
    rstn = 1'b0;
    #2;
    check_reset_values("midrst");
    tick();
    rstn = 1'b1;
    tick();
    check("midrst_state_after", state, 0);
    check("midrst_unlocked_after", locked, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
